// File: rtl/fetch_prefetch_queue_pkg.sv
// Shared types for the instruction prefetch front end: FSM states, queue entry
// layout, opcodes and J/B immediate decoders. FETCH_BTFN_EN adds pred_taken to entries.
package fetch_pkg;

    localparam int FETCH_XLEN = 32;

    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [FETCH_XLEN-1:0] pc;
        logic [FETCH_XLEN-1:0] ins;
`ifdef FETCH_BTFN_EN
        logic                  pred_taken;
`endif
    } fetch_entry_t;

    function automatic logic [31:0] imm_j(input logic [31:0] ins);
        return {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
    endfunction

    function automatic logic [31:0] imm_b(input logic [31:0] ins);
        return {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
    endfunction

endpackage

// File: rtl/fetch_prefetch_queue_if.sv
// Fetch front-end bus: instruction-memory request/response, redirect and the
// decode-side valid/ready head. pred_taken exists only with FETCH_BTFN_EN.
interface fetch_prefetch_queue_if #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic            imem_req_valid;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_req_ready;
    logic            imem_rsp_valid;
    logic [XLEN-1:0] imem_rsp_data;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            ins_valid;
    logic [XLEN-1:0] ins;
    logic [XLEN-1:0] ins_pc;
    logic            ins_ready;
    logic [CW-1:0]   count;
`ifdef FETCH_BTFN_EN
    logic            pred_taken;

    modport master (
        output imem_req_valid, imem_req_addr, ins_valid, ins, ins_pc, count, pred_taken,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, ins_ready
    );
    modport slave (
        input  imem_req_valid, imem_req_addr, ins_valid, ins, ins_pc, count, pred_taken,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, ins_ready
    );
`else
    modport master (
        output imem_req_valid, imem_req_addr, ins_valid, ins, ins_pc, count,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, ins_ready
    );
    modport slave (
        input  imem_req_valid, imem_req_addr, ins_valid, ins, ins_pc, count,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, ins_ready
    );
`endif
endinterface

// File: rtl/fetch_prefetch_queue_fifo.sv
// DEPTH-entry FIFO with synchronous flush; head is read straight from the
// storage registers so it carries no combinational path from the push side.
module fetch_fifo #(
    parameter  int DEPTH = 4,
    parameter  int W     = 64,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic [W-1:0]  head,
    output logic [CW-1:0] count
);
    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/fetch_prefetch_queue.sv
// Instruction prefetch front end: one outstanding imem request, responses queued
// with their PC, redirect flushes everything. FETCH_BTFN_EN enables BTFN prediction.
module fetch_prefetch_queue
    import fetch_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    fetch_prefetch_queue_if.master        bus
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int EW = $bits(fetch_entry_t);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;

    logic            req_valid, accept, push, pop, redirect;
    logic [CW-1:0]   count;
    fetch_entry_t    push_entry, head_entry;

    assign redirect = bus.redirect_valid;

    // Only issue when a slot is guaranteed free for the response.
    assign req_valid = rst_n && (state_q == IDLE) && (count < CW'(DEPTH)) && !redirect;
    assign accept    = req_valid && bus.imem_req_ready;
    assign push      = (state_q == WAIT) && bus.imem_rsp_valid && !redirect;
    assign pop       = (count != '0) && bus.ins_ready && !redirect;

`ifdef FETCH_BTFN_EN
    logic [6:0]      opcode;
    logic            pred;
    logic [XLEN-1:0] target;

    assign opcode = bus.imem_rsp_data[6:0];
    assign pred   = (opcode == OP_JAL) || ((opcode == OP_BRANCH) && bus.imem_rsp_data[31]);
    assign target = req_pc_q + ((opcode == OP_JAL) ? imm_j(bus.imem_rsp_data)
                                                    : imm_b(bus.imem_rsp_data));
`endif

    always_comb begin
        push_entry     = '0;
        push_entry.pc  = req_pc_q;
        push_entry.ins = bus.imem_rsp_data;
`ifdef FETCH_BTFN_EN
        push_entry.pred_taken = pred;
`endif
    end

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        case (state_q)
            IDLE: if (accept) begin
                state_d    = WAIT;
                req_pc_d   = fetch_pc_q;
                fetch_pc_d = fetch_pc_q + XLEN'(4);
            end
            WAIT: begin
                if (bus.imem_rsp_valid) state_d = IDLE;
                else if (redirect)      state_d = DROP;
            end
            DROP: if (bus.imem_rsp_valid) state_d = IDLE;
            default: state_d = IDLE;
        endcase
`ifdef FETCH_BTFN_EN
        if (push && pred) fetch_pc_d = target;
`endif
        if (redirect) fetch_pc_d = bus.redirect_pc & ~XLEN'(3);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head      (head_entry),
        .count     (count)
    );

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = fetch_pc_q;
    assign bus.ins_valid      = (count != '0);
    assign bus.ins            = head_entry.ins;
    assign bus.ins_pc         = head_entry.pc;
    assign bus.count          = count;
`ifdef FETCH_BTFN_EN
    assign bus.pred_taken     = head_entry.pred_taken;
`endif

endmodule

// File: doc/fetch_prefetch_queue.md
Name: fetch_prefetch_queue

Overview:
- Parametrised instruction-fetch front end for the RV32 core. It replaces the directly driven 32-bit `ins` input of the single-cycle processor.
- Holds its own PC and issues word-aligned requests to instruction memory. It buffers returned instructions with their PCs in a DEPTH-entry FIFO and presents them to decode over a valid/ready handshake.
- A redirect port (branch/jump resolution from the core) flushes the queue and restarts fetch. Any response still in flight is discarded.

Parameters:
- XLEN, 32, width of PC and instruction words.
- DEPTH, 4, prefetch queue entries; power of two, minimum 2.
- RESET_PC, 32'h0000_0000, fetch address after reset; must be 4-byte aligned.

Ports:
- clk  in  1  clock, rising-edge.
- rst_n  in  1  reset, synchronous, active-low.
- imem_req_valid  out  1  fetch request valid.
- imem_req_addr  out  XLEN  fetch address; bits [1:0] always 0.
- imem_req_ready  in  1  memory accepts request this cycle.
- imem_rsp_valid  in  1  response data valid; at least 1 cycle after the accepting cycle.
- imem_rsp_data  in  XLEN  instruction word.
- redirect_valid  in  1  flush and restart fetch.
- redirect_pc  in  XLEN  new fetch address.
- ins_valid  out  1  queue head valid.
- ins  out  XLEN  head instruction.
- ins_pc  out  XLEN  PC of head instruction.
- ins_ready  in  1  decode consumes head this cycle.
- count  out  $clog2(DEPTH)+1  occupied entries.

Behaviour:
- Clock and reset: one clock `clk`. Reset is synchronous, active-low (`rst_n` sampled on the rising edge).
- Reset values:
  - fetch_pc = RESET_PC.
  - FSM in IDLE; queue empty; count = 0.
  - ins_valid = 0, imem_req_valid = 0, ins = 0, ins_pc = 0.
  - Reset asserted mid-transaction abandons any outstanding request. No response is pushed afterwards; responses arriving while in reset are ignored.
- FSM states IDLE, WAIT, DROP. At most one request outstanding.
  - IDLE:
    - imem_req_valid = (count < DEPTH) && !redirect_valid, with imem_req_addr = fetch_pc.
    - On valid && ready: go to WAIT, req_pc <= fetch_pc, fetch_pc <= fetch_pc + 4 (wraps modulo 2^XLEN).
  - WAIT: imem_req_valid = 0. On imem_rsp_valid, push {req_pc, imem_rsp_data} and go to IDLE.
  - DROP: imem_req_valid = 0. On imem_rsp_valid, discard the data and go to IDLE.
- Space reservation: a request is only issued when count < DEPTH. A push in WAIT therefore never overflows, even with no pop that cycle.
- Pop: when ins_valid && ins_ready, the head is removed at the clock edge. ins, ins_pc and ins_valid come from registered queue state (no combinational path from imem_rsp_*).
- Simultaneous push and pop: count unchanged, both take effect.
- Pop when empty: no effect, since ins_valid = 0.
- Redirect has highest priority on the same cycle:
  - Queue flushed: count = 0, ins_valid = 0 next cycle.
  - fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00}.
  - Any concurrent pop or push is cancelled.
  - A response arriving in that same cycle is discarded.
  - State transitions:
    - IDLE → IDLE; no request is driven that cycle.
    - WAIT → DROP, unless imem_rsp_valid is also high that cycle, in which case → IDLE.
    - DROP → DROP, or → IDLE if the response arrives in the same cycle.
- Latency: with 1-cycle memory and ins_ready = 1 throughput is one instruction per two cycles. First ins_valid appears 3 cycles after rst_n rises.
- count: exact registered occupancy, 0..DEPTH.

Optional Feature:
- Macro: FETCH_BTFN_EN.
- Defined: at push, the word is pre-decoded.
  - If opcode is JAL (1101111), or opcode is B-type (1100011) with imm[12] = 1 (backward), then fetch_pc <= req_pc + sign-extended J/B immediate instead of sequential +4.
  - An extra 1-bit `pred_taken` output accompanies each head entry.
  - A redirect still overrides everything.
- Undefined: purely sequential fetch; `pred_taken` port absent.

Decomposition:
- Package fetch_pkg:
  - Opcode constants OP_JAL and OP_BRANCH.
  - State enum {IDLE, WAIT, DROP}.
  - Queue entry struct {pc, ins[, pred_taken]}.
  - J/B immediate extraction functions, shared with immediateGenerator.
- Sub-module fetch_fifo (parametrised DEPTH, entry width):
  - Synchronous flush input.
  - Push, pop, count, head outputs.

Test Plan:
- Reset with RESET_PC = 0, memory ready = 1, 1-cycle response, ins_ready = 1 → requests at 0x0, 0x4, 0x8. Instructions 0x00b00533, 0x02000513 appear in order with ins_pc 0x0, 0x4.
- ins_ready = 0 for 20 cycles, DEPTH = 4 → exactly 4 requests, count = 4, imem_req_valid stays 0. Release ready → fetch resumes at 0x10.
- redirect_valid with redirect_pc = 0x40 while in WAIT; response 0xfedff0ef arrives next cycle → response discarded, count = 0, next request at 0x40.
- redirect_pc = 0x43 → request at 0x40.
- Same-cycle redirect and pop with count = 3 → count = 0 next cycle, ins_valid = 0.
- rst_n low for one cycle while in WAIT, response arrives after release → not pushed, first request at RESET_PC. With FETCH_BTFN_EN: fetch 0xfedff0ef at PC 0x20 → next request at 0x0C, pred_taken = 1.
